// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks in-flight destination registers and produces registered operand mux
// selects for the EX stage plus a combinational load-use stall toward ID/IF.
// The WB-stage producer needs no state here: a reader in ID sees its value
// through register file write-through, so only EX and MEM are tracked.
module fwd_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic                id_uses_rm,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                flush,
    output logic [1:0]          fwd_sel_a,
    output logic [1:0]          fwd_sel_b,
    output logic                stall
);

    localparam logic [REG_BITS-1:0] ZERO = REG_BITS'(ZERO_REG);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // EX slot: instruction whose operands are being selected right now
    logic                ex_valid;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_reg_write;
    logic                ex_mem_read;

    // MEM slot: only its write-back identity matters for forwarding
    logic                mem_valid;
    logic [REG_BITS-1:0] mem_rd;
    logic                mem_reg_write;

    logic       ex_hit_a;
    logic       ex_hit_b;
    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       advance;
    logic [1:0] next_sel_a;
    logic [1:0] next_sel_b;

    // A slot produces r when it holds a real register-writing instruction
    // targeting r, and r is not the hardwired zero register
    function automatic logic producer_match(
        input logic                valid,
        input logic                reg_write,
        input logic [REG_BITS-1:0] rd,
        input logic [REG_BITS-1:0] r
    );
        return valid & reg_write & (rd == r) & (r != ZERO);
    endfunction

    // Hazard detection and next-select computation for the instruction in ID
    always_comb begin
        ex_hit_a   = producer_match(ex_valid, ex_reg_write, ex_rd, id_rn);
        ex_hit_b   = producer_match(ex_valid, ex_reg_write, ex_rd, id_rm);
        mem_hit_a  = producer_match(mem_valid, mem_reg_write, mem_rd, id_rn);
        mem_hit_b  = producer_match(mem_valid, mem_reg_write, mem_rd, id_rm);

        stall      = id_valid & ~flush & ex_mem_read &
                     (ex_hit_a | (id_uses_rm & ex_hit_b));
        advance    = id_valid & ~flush & ~stall;

        next_sel_a = SEL_RF;
        if (ex_hit_a) begin
            next_sel_a = SEL_EX;
        end else if (mem_hit_a) begin
            next_sel_a = SEL_MEM;
        end

        next_sel_b = SEL_RF;
        if (id_uses_rm) begin
            if (ex_hit_b) begin
                next_sel_b = SEL_EX;
            end else if (mem_hit_b) begin
                next_sel_b = SEL_MEM;
            end
        end
    end

    // Shift the tracking slots and register selects alongside the EX operands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            fwd_sel_a     <= SEL_RF;
            fwd_sel_b     <= SEL_RF;
        end else begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            ex_valid      <= advance;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            fwd_sel_a     <= advance ? next_sel_a : SEL_RF;
            fwd_sel_b     <= advance ? next_sel_b : SEL_RF;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed checking of fwd_hazard_unit against a small
// pipeline-occupancy model that searches the in-flight stages for producers.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_uses_rm;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       stall;

    int total_checks;
    int bad_checks;
    logic seen_stall;

    // In-flight instruction record; index 0 is EX, index 1 is MEM
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wr;
        bit       mr;
    } slot_t;

    slot_t pipe[2];
    bit [1:0] exp_sel_a;
    bit [1:0] exp_sel_b;

    fwd_hazard_unit #(.REG_BITS(5), .ZERO_REG(31)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_uses_rm   (id_uses_rm),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] expv);
        total_checks++;
        if (got !== expv) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, expv, $time);
        end
    endtask

    // Nearest in-flight stage producing r (0=EX, 1=MEM), or -1 if none
    function automatic int producer_stage(input bit [4:0] r);
        for (int s = 0; s < 2; s++) begin
            if (pipe[s].valid && pipe[s].wr && pipe[s].rd == r && r != 5'd31) return s;
        end
        return -1;
    endfunction

    // Select code is one past the producing stage: none->0, EX->1, MEM->2
    function automatic bit [1:0] sel_code(input bit [4:0] r);
        return 2'(producer_stage(r) + 1);
    endfunction

    function automatic bit model_stall();
        if (!id_valid || flush || !pipe[0].mr) return 1'b0;
        return (producer_stage(id_rn) == 0) || (id_uses_rm && producer_stage(id_rm) == 0);
    endfunction

    task automatic model_reset();
        pipe[0] = '{default: 0};
        pipe[1] = '{default: 0};
        exp_sel_a = 2'b00;
        exp_sel_b = 2'b00;
    endtask

    // One clock: entered and left at a falling edge
    task automatic apply_stimulus(input bit v, input bit [4:0] rn, input bit [4:0] rm,
                                  input bit uses, input bit [4:0] rd, input bit wr,
                                  input bit mr, input bit fl);
        bit accept;
        bit exp_stall;
        id_valid     = v;
        id_rn        = rn;
        id_rm        = rm;
        id_uses_rm   = uses;
        id_rd        = rd;
        id_reg_write = wr;
        id_mem_read  = mr;
        flush        = fl;
        #1;
        exp_stall  = model_stall();
        seen_stall = stall;
        check_output("stall", {7'd0, stall}, {7'd0, exp_stall});
        accept = v && !fl && !exp_stall;
        @(posedge clk);
        exp_sel_a = accept ? sel_code(rn) : 2'b00;
        exp_sel_b = (accept && uses) ? sel_code(rm) : 2'b00;
        pipe[1] = pipe[0];
        if (accept) pipe[0] = '{valid: 1'b1, rd: rd, wr: wr, mr: mr};
        else        pipe[0] = '{default: 0};
        @(negedge clk);
        check_output("sel_a", {6'd0, fwd_sel_a}, {6'd0, exp_sel_a});
        check_output("sel_b", {6'd0, fwd_sel_b}, {6'd0, exp_sel_b});
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    // Main sequence: reset, directed cases, randomized traffic
    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset_n      = 1'b0;
        id_valid     = 1'b0;
        id_rn        = '0;
        id_rm        = '0;
        id_uses_rm   = 1'b0;
        id_rd        = '0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        flush        = 1'b0;
        model_reset();
        #3;
        check_output("rst_sel_a", {6'd0, fwd_sel_a}, 8'd0);
        check_output("rst_sel_b", {6'd0, fwd_sel_b}, 8'd0);
        check_output("rst_stall", {7'd0, stall}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // EX forwarding: ADD X1,X2,X3 ; SUB X4,X1,X5
        apply_stimulus(1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0);
        apply_stimulus(1, 5'd1, 5'd5, 1, 5'd4, 1, 0, 0);
        check_output("dir_ex_a", {6'd0, fwd_sel_a}, 8'h01);
        check_output("dir_ex_b", {6'd0, fwd_sel_b}, 8'h00);
        idle_cycle();
        idle_cycle();

        // MEM forwarding: ADD X1 ; ORR X7 ; AND X8,X9,X1
        apply_stimulus(1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0);
        apply_stimulus(1, 5'd2, 5'd3, 1, 5'd7, 1, 0, 0);
        apply_stimulus(1, 5'd9, 5'd1, 1, 5'd8, 1, 0, 0);
        check_output("dir_mem_b", {6'd0, fwd_sel_b}, 8'h02);

        // Priority: ADD X1 ; ADD X1 ; AND X8,X1,X1
        apply_stimulus(1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0);
        apply_stimulus(1, 5'd2, 5'd3, 1, 5'd1, 1, 0, 0);
        apply_stimulus(1, 5'd1, 5'd1, 1, 5'd8, 1, 0, 0);
        check_output("dir_pri_a", {6'd0, fwd_sel_a}, 8'h01);
        check_output("dir_pri_b", {6'd0, fwd_sel_b}, 8'h01);
        idle_cycle();
        idle_cycle();

        // Load-use: LDUR X2,[X0] ; ADD X3,X2,X2 held for one stall
        apply_stimulus(1, 5'd0, 5'd0, 0, 5'd2, 1, 1, 0);
        apply_stimulus(1, 5'd2, 5'd2, 1, 5'd3, 1, 0, 0);
        check_output("dir_lu_stall", {7'd0, seen_stall}, 8'h01);
        check_output("dir_lu_bubble", {6'd0, fwd_sel_a}, 8'h00);
        apply_stimulus(1, 5'd2, 5'd2, 1, 5'd3, 1, 0, 0);
        check_output("dir_lu_nostall", {7'd0, seen_stall}, 8'h00);
        check_output("dir_lu_a", {6'd0, fwd_sel_a}, 8'h02);
        check_output("dir_lu_b", {6'd0, fwd_sel_b}, 8'h02);
        idle_cycle();
        idle_cycle();

        // XZR never forwarded; a store (no reg write) never forwarded
        apply_stimulus(1, 5'd1, 5'd2, 1, 5'd31, 1, 0, 0);
        apply_stimulus(1, 5'd31, 5'd5, 1, 5'd4, 1, 0, 0);
        check_output("dir_xzr_a", {6'd0, fwd_sel_a}, 8'h00);
        apply_stimulus(1, 5'd1, 5'd6, 1, 5'd6, 0, 0, 0);
        apply_stimulus(1, 5'd6, 5'd6, 1, 5'd9, 1, 0, 0);
        check_output("dir_stur_a", {6'd0, fwd_sel_a}, 8'h00);
        idle_cycle();
        idle_cycle();

        // Flush over a pending load-use pair: no stall, bubble into EX
        apply_stimulus(1, 5'd0, 5'd0, 0, 5'd2, 1, 1, 0);
        apply_stimulus(1, 5'd2, 5'd2, 1, 5'd3, 1, 0, 1);
        check_output("dir_fl_stall", {7'd0, seen_stall}, 8'h00);
        check_output("dir_fl_a", {6'd0, fwd_sel_a}, 8'h00);
        idle_cycle();
        idle_cycle();

        // Reset pulsed between a load and its consumer
        apply_stimulus(1, 5'd0, 5'd0, 0, 5'd2, 1, 1, 0);
        id_valid = 1; id_rn = 5'd2; id_rm = 5'd2; id_uses_rm = 1;
        id_rd = 5'd3; id_reg_write = 1; id_mem_read = 0; flush = 0;
        #1;
        check_output("pre_rst_stall", {7'd0, stall}, 8'h01);
        reset_n = 1'b0;
        #1;
        check_output("mid_rst_stall", {7'd0, stall}, 8'h00);
        check_output("mid_rst_sel_a", {6'd0, fwd_sel_a}, 8'h00);
        check_output("mid_rst_sel_b", {6'd0, fwd_sel_b}, 8'h00);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1, 5'd2, 5'd2, 1, 5'd3, 1, 0, 0);
        check_output("post_rst_stall", {7'd0, seen_stall}, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 7) != 0, pick_reg(), pick_reg(),
                           $urandom_range(0, 1) == 1, pick_reg(),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
